// File: rtl/stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_packer_pkg
// Brief   : Shared types and helpers for the record-path stream packer.
// Revision: 1.0 - initial release
// ============================================================================
package stream_packer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_PACK_RATIO = 4;
    localparam int DEF_TIMEOUT    = 16;

    // Source of the word loaded into the output register this cycle.
    typedef enum logic [1:0] {
        EMIT_NONE  = 2'd0,
        EMIT_FULL  = 2'd1,
        EMIT_FLUSH = 2'd2
    } emit_e;

    function automatic int lane_idx_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit pack_ratio_legal(input int ratio);
        return (ratio >= 2) && ((ratio & (ratio - 1)) == 0);
    endfunction

    // Mask with the lowest 'fill' lanes set.
    function automatic logic [63:0] keep_mask(input int fill);
        return (64'd1 << fill) - 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module  : stream_packer_if
// Brief   : Narrow input and wide output valid/ready channels of the packer.
// Revision: 1.0 - initial release
// ============================================================================
interface stream_packer_if #(
    parameter int DATA_WIDTH = stream_packer_pkg::DEF_DATA_WIDTH,
    parameter int PACK_RATIO = stream_packer_pkg::DEF_PACK_RATIO
);
    logic                             in_valid;
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_ready;
    logic                             out_valid;
    logic [DATA_WIDTH*PACK_RATIO-1:0] out_data;
    logic [PACK_RATIO-1:0]            out_keep;
    logic                             out_ready;

    // Environment side: produces narrow beats, consumes packed words.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_keep
    );

    // Packer side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_keep
    );
endinterface
`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module  : stream_packer
// Brief   : Packs PACK_RATIO narrow beats into one wide beat with keep mask.
//           Optional partial-word flush: STREAM_PACKER_FLUSH_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module stream_packer
    import stream_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PACK_RATIO = DEF_PACK_RATIO,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  wire logic           clk,
    input  wire logic           rstn,
    stream_packer_if.slave      sp_io
);

    localparam int                CNT_W     = lane_idx_w(PACK_RATIO);
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(PACK_RATIO - 1);

    typedef logic [PACK_RATIO-1:0][DATA_WIDTH-1:0] lanes_t;

    if (!pack_ratio_legal(PACK_RATIO)) begin : g_bad_ratio
        $error("stream_packer: PACK_RATIO must be a power of 2 and >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("stream_packer: TIMEOUT must be >= 1");
    end

    lanes_t                acc_q, acc_d;
    lanes_t                out_data_q, out_data_d;
    logic [PACK_RATIO-1:0] out_keep_q, out_keep_d;
    logic                  out_valid_q, out_valid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic  w_slot_free;
    logic  w_insert;
    logic  w_remove;
    logic  w_complete;
    logic  w_flush;
    emit_e w_emit;

    // Output slot can take a new word if empty or being drained this cycle.
    assign w_slot_free    = !out_valid_q || sp_io.out_ready;
    assign sp_io.in_ready = (cnt_q != LAST_LANE) || w_slot_free;
    assign w_insert       = sp_io.in_valid && sp_io.in_ready;
    assign w_remove       = out_valid_q && sp_io.out_ready;
    assign w_complete     = w_insert && (cnt_q == LAST_LANE);

`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
    localparam int               IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

    logic [IDLE_W-1:0] idle_q, idle_d;

    assign w_flush = (idle_q == IDLE_MAX) && (cnt_q != '0) && !w_insert && w_slot_free;

    always_comb begin
        idle_d = idle_q;
        if (w_insert || (cnt_q == '0) || w_flush) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    always_comb begin
        w_emit = EMIT_NONE;
        if (w_complete) begin
            w_emit = EMIT_FULL;
        end else if (w_flush) begin
            w_emit = EMIT_FLUSH;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;

        if (w_insert) begin
            acc_d[cnt_q] = sp_io.in_data;
            cnt_d        = cnt_q + 1'b1;
        end

        // Accumulator is cleared on every emit so a flushed word's unfilled lanes read 0.
        case (w_emit)
            EMIT_FULL: begin
                out_data_d  = acc_d;
                out_keep_d  = '1;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end
            EMIT_FLUSH: begin
                out_data_d  = acc_q;
                out_keep_d  = PACK_RATIO'(keep_mask(int'(cnt_q)));
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end
            default: begin
                if (w_remove) begin
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sp_io.out_valid = out_valid_q;
    assign sp_io.out_data  = out_data_q;
    assign sp_io.out_keep  = out_keep_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_packer
// Brief   : Scoreboard bench for stream_packer (DATA_WIDTH=32, PACK_RATIO=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_packer;
    import stream_packer_pkg::*;

    localparam int DW = 32;
    localparam int PR = 4;
    localparam int TO = 16;
    localparam int WW = DW * PR;

    typedef struct packed {
        logic [WW-1:0] data;
        logic [PR-1:0] keep;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    stream_packer_if #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) bus ();

    stream_packer #(
        .DATA_WIDTH (DW),
        .PACK_RATIO (PR),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .sp_io (bus)
    );

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    bit            rand_ready = 1'b0;
    logic [DW-1:0] lanes [PR];

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [WW-1:0] pack4(input logic [DW-1:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push_exp(input logic [WW-1:0] d, input logic [PR-1:0] k);
        exp_t e;
        e.data = d;
        e.keep = k;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: beat %0h never accepted, required acceptance", d);
                break;
            end
            tick();
        end
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hBAD0_BEEF;
    endtask

    // Monitor: pops the scoreboard on every remove and checks hold-stability.
    logic          pv, pr;
    logic [WW-1:0] pd;
    logic [PR-1:0] pk;
    initial begin
        pv = 1'b0; pr = 1'b0; pd = '0; pk = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (pv && !pr) begin
                    chk("hold_valid", WW'(bus.out_valid), WW'(1));
                    chk("hold_data", bus.out_data, pd);
                    chk("hold_keep", WW'(bus.out_keep), WW'(pk));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got %0h required none", bus.out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("word_data", bus.out_data, mon_e.data);
                        chk("word_keep", WW'(bus.out_keep), WW'(mon_e.keep));
                    end
                end
            end
            pv = bus.out_valid && rstn;
            pr = bus.out_ready;
            pd = bus.out_data;
            pk = bus.out_keep;
        end
    end

    initial begin
        #3000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rstn          = 1'b0;
        repeat (3) tick();
        chk("rst_out_valid", WW'(bus.out_valid), WW'(0));
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_keep", WW'(bus.out_keep), WW'(0));
        chk("rst_in_ready", WW'(bus.in_ready), WW'(1));
        rstn = 1'b1;
        tick();

        // Continuous stream 0..7, consumer always ready.
        bus.out_ready = 1'b1;
        push_exp(128'h00000003_00000002_00000001_00000000, 4'hF);
        push_exp(pack4(4, 5, 6, 7), 4'hF);
        for (int i = 0; i < 4; i++) send(DW'(i));
        chk("lat_word0", WW'(bus.out_valid), WW'(1));
        send(4);
        chk("pulse_word0", WW'(bus.out_valid), WW'(0));
        for (int i = 5; i < 8; i++) send(DW'(i));
        chk("lat_word1", WW'(bus.out_valid), WW'(1));
        tick();
        chk("pulse_word1", WW'(bus.out_valid), WW'(0));

        // Back-pressure: word held, three more beats fit, the fourth stalls.
        bus.out_ready = 1'b0;
        push_exp(pack4(8, 9, 10, 11), 4'hF);
        push_exp(pack4(12, 13, 14, 15), 4'hF);
        for (int i = 8; i < 15; i++) send(DW'(i));
        bus.in_valid = 1'b1;
        bus.in_data  = 15;
        repeat (8) tick();
        @(negedge clk);
        chk("stall_in_ready", WW'(bus.in_ready), WW'(0));
        chk("stall_out_valid", WW'(bus.out_valid), WW'(1));
        tick();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", WW'(bus.in_ready), WW'(1));
        tick();
        bus.in_valid = 1'b0;
        chk("overlap_valid", WW'(bus.out_valid), WW'(1));
        chk("overlap_data", bus.out_data, pack4(12, 13, 14, 15));
        tick();
        chk("overlap_drained", WW'(bus.out_valid), WW'(0));

        // Reset with two lanes filled: they must be discarded.
        send(100);
        send(101);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_valid", WW'(bus.out_valid), WW'(0));
        chk("midrst_keep", WW'(bus.out_keep), WW'(0));
        push_exp(pack4(200, 201, 202, 203), 4'hF);
        for (int i = 200; i < 204; i++) send(DW'(i));
        chk("midrst_word_valid", WW'(bus.out_valid), WW'(1));
        tick();

`ifdef STREAM_PACKER_FLUSH_TIMEOUT_EN
        begin
            int lat;
            bit seen;
            lat = 0;
            push_exp(pack4(300, 301, 302, 0), 4'b0111);
            send(300); send(301); send(302);
            for (int k = 1; k <= 40; k++) begin
                tick();
                if (bus.out_valid) begin
                    lat = k;
                    break;
                end
            end
            chk("flush_latency", WW'(lat), WW'(17));
            tick();
            // A beat on idle cycle 15 restarts the count.
            push_exp(pack4(400, 401, 402, 403), 4'hF);
            send(400); send(401);
            repeat (14) tick();
            send(402);
            seen = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (bus.out_valid) seen = 1'b1;
            end
            chk("no_flush_after_restart", WW'(seen), WW'(0));
            send(403);
            chk("restart_word_valid", WW'(bus.out_valid), WW'(1));
            tick();
        end
`else
        // Partial word is held indefinitely.
        push_exp(pack4(300, 301, 302, 303), 4'hF);
        send(300); send(301); send(302);
        repeat (40) tick();
        chk("partial_held", WW'(bus.out_valid), WW'(0));
        send(303);
        chk("partial_complete", WW'(bus.out_valid), WW'(1));
        tick();
`endif

        // Random gaps on input and random consumer readiness.
        rand_ready = 1'b1;
        for (int w = 0; w < 200; w++) begin
            for (int l = 0; l < PR; l++) lanes[l] = $urandom;
            push_exp(pack4(lanes[0], lanes[1], lanes[2], lanes[3]), 4'hF);
            for (int l = 0; l < PR; l++) begin
                if ($urandom_range(0, 1) == 1) tick();
                send(lanes[l]);
            end
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
        repeat (2) tick();
        chk("scoreboard_empty", WW'(exp_q.size()), WW'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
